// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port (wclk domain) among NREQ requesters,
// with bounded bursts of MAX_BURST words. Define FIFO_ARB_PRIORITY_EN to give requester 0 fixed priority.
module fifo_write_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
        logic          found;
        logic [OW-1:0] pick;
        int            idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
        return pick;
    endfunction

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
`ifdef FIFO_ARB_PRIORITY_EN
                    if (req[0]) owner_d = '0;
                    else        owner_d = rr_pick({req[NREQ-1:1], 1'b0}, rr_ptr_q);
`else
                    owner_d = rr_pick(req, rr_ptr_q);
`endif
                    burst_cnt_d = '0;
                    state_d     = OWN;
                end
            end
            OWN: begin
                if (winc) burst_cnt_d = burst_cnt_q + CW'(1);
                // A withdrawn request ends the grant even while the FIFO is full.
                if ((winc && burst_cnt_q == CW'(MAX_BURST - 1)) || !req[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == OWN);
        owner = owner_q;
        winc  = busy && req[owner_q] && !wfull && !wrst;
        ack   = '0;
        ack[owner_q] = winc;
        wdata = winc ? req_data[owner_q*DSIZE +: DSIZE] : '0;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NREQ=4, MAX_BURST=4, DSIZE=8).
module tb_fifo_write_arbiter;
  localparam int DSIZE = 8;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 4;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              wfull;
  logic              winc;
  logic [DSIZE-1:0]  wdata;
  logic              busy;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;
  int writes;
  logic [7:0] t2_data [3] = '{8'h11, 8'h22, 8'h33};
  logic [1:0] exp_own;

  fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .owner(owner)
  );

  always #5 wclk = ~wclk;

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_winc, input logic [3:0] e_ack,
                            input logic [7:0] e_wdata, input logic e_busy);
    check({tag, " winc"}, 32'(winc), 32'(e_winc));
    check({tag, " ack"}, 32'(ack), 32'(e_ack));
    check({tag, " wdata"}, 32'(wdata), 32'(e_wdata));
    check({tag, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    req = '0;
    wfull = 1'b0;
    cyc();
    wrst = 1'b0;
  endtask

  initial begin
    // Test 1: reset held with all requests high
    wrst = 1'b1;
    req = 4'b1111;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    wfull = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_out("t1 reset", 1'b0, 4'b0000, 8'h00, 1'b0);
      check("t1 owner", 32'(owner), 32'd0);
      cyc();
    end

    // Test 2: single requester, three words then withdraw
    wrst = 1'b0;
    req = 4'b0100;
    req_data[2*8 +: 8] = t2_data[0];
    settle();
    expect_out("t2 idle", 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      settle();
      expect_out("t2 write", 1'b1, 4'b0100, t2_data[i], 1'b1);
      check("t2 owner", 32'(owner), 32'd2);
      cyc();
      if (i < 2) req_data[2*8 +: 8] = t2_data[i+1];
    end
    req = 4'b0000;
    settle();
    expect_out("t2 release", 1'b0, 4'b0000, 8'h00, 1'b1);
    cyc();
    settle();
    check("t2 busy after", 32'(busy), 32'd0);
    check("t2 rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // Test 3: all requesters, sustained round-robin
    do_reset();
    req = 4'b1111;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    writes = 0;
    for (int j = 0; j < 25; j++) begin
      settle();
      exp_own = 2'((j / 5) % 4);
      if (j % 5 == 0) begin
        expect_out("t3 idle", 1'b0, 4'b0000, 8'h00, 1'b0);
      end else begin
        expect_out("t3 burst", 1'b1, 4'(1 << exp_own), req_data[exp_own*8 +: 8], 1'b1);
        check("t3 owner", 32'(owner), 32'(exp_own));
      end
      if (j < 20 && winc) writes++;
      cyc();
    end
    check("t3 writes in 20", 32'(writes), 32'd16);

    // Test 4: wfull stall mid-burst for owner 1
    do_reset();
    req = 4'b0010;
    req_data = {8'h04, 8'h03, 8'h55, 8'h01};
    cyc();
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_out("t4 pre-stall", 1'b1, 4'b0010, 8'h55, 1'b1);
      cyc();
    end
    wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      expect_out("t4 stall", 1'b0, 4'b0000, 8'h00, 1'b1);
      check("t4 owner", 32'(owner), 32'd1);
      check("t4 burst_cnt", 32'(dut.burst_cnt_q), 32'd2);
      cyc();
    end
    wfull = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_out("t4 post-stall", 1'b1, 4'b0010, 8'h55, 1'b1);
      cyc();
    end
    settle();
    expect_out("t4 released", 1'b0, 4'b0000, 8'h00, 1'b0);

    // Test 5: reset during owner 2's burst
    do_reset();
    req = 4'b0100;
    req_data = {8'h04, 8'h77, 8'h02, 8'h01};
    cyc();
    for (int i = 0; i < 2; i++) begin
      settle();
      expect_out("t5 burst", 1'b1, 4'b0100, 8'h77, 1'b1);
      cyc();
    end
    wrst = 1'b1;
    settle();
    check("t5 winc in reset", 32'(winc), 32'd0);
    check("t5 ack in reset", 32'(ack), 32'd0);
    check("t5 wdata in reset", 32'(wdata), 32'd0);
    cyc();
    wrst = 1'b0;
    req = 4'b1100;
    settle();
    check("t5 busy after reset", 32'(busy), 32'd0);
    check("t5 rr_ptr after reset", 32'(dut.rr_ptr_q), 32'd0);
    cyc();
    settle();
    check("t5 owner", 32'(owner), 32'd2);
    expect_out("t5 regrant", 1'b1, 4'b0100, 8'h77, 1'b1);

    // Test 6: owner 1 withdraws with req 0 and 3 pending
    do_reset();
    req = 4'b0010;
    req_data = {8'h3C, 8'h02, 8'h1B, 8'h0A};
    cyc();
    settle();
    expect_out("t6 owner1 write", 1'b1, 4'b0010, 8'h1B, 1'b1);
    cyc();
    req = 4'b1001;
    settle();
    expect_out("t6 release", 1'b0, 4'b0000, 8'h00, 1'b1);
    cyc();
    settle();
    check("t6 idle", 32'(busy), 32'd0);
    check("t6 rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    cyc();
    settle();
`ifdef FIFO_ARB_PRIORITY_EN
    exp_own = 2'd0;
`else
    exp_own = 2'd3;
`endif
    check("t6 next owner", 32'(owner), 32'(exp_own));
    expect_out("t6 next write", 1'b1, 4'(1 << exp_own), req_data[exp_own*8 +: 8], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
